// File: rtl/spi_pkg.sv
// Shared SPI definitions: bus mode and the receive-side push handshake states.
package spi_pkg;

  // SPI mode 0: SCLK idles low, data sampled on rise, changed on fall.
  localparam int SPI_MODE = 0;

  // Idle level of SCLK implied by the mode (CPOL bit).
  localparam logic SCLK_IDLE = (SPI_MODE >= 2) ? 1'b1 : 1'b0;

  // Push handshake towards the word consumer.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQUEST   = 2'd1,
    WAIT_DONE = 2'd2
  } push_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Receive word FIFO: power-of-two depth, registered head read, full/empty flags.
// A write while full is ignored (the caller flags the drop); write and pop in
// the same cycle both take effect.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_reg;
  logic [AW:0]          rd_ptr_reg;
  logic [DATA_SIZE-1:0] rd_data_reg;
  logic                 wr_ok;
  logic                 rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Storage array, written only when there is room.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  // Read and write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Registered head read; the head slot cannot be overwritten while it is
  // occupied, so the value stays stable until the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_reg <= '0;
    end else begin
      rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/spi_receiver.sv
// SPI mode-0 slave: receives words into a FIFO and pushes them to a consumer
// with a request/done handshake; transmits words from a one-deep holding
// register on MISO, full duplex.
module spi_receiver
  import spi_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 nCS,
  input  logic                 SCLK,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_request,
  input  logic                 out_done,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic                 in_request,
  output logic                 in_done,
  output logic                 overflow,
  output logic                 underrun
);

  localparam int                CNT_W    = $clog2(DATA_SIZE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_SIZE - 1);

  // Synchronizer chains (meta, sync, previous-for-edge-detect).
  logic ncs_meta_reg, ncs_sync_reg, ncs_prev_reg;
  logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
  logic mosi_meta_reg, mosi_sync_reg;

  // Edge and qualifier strobes derived from the synchronized signals.
  logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, selected;
  logic rx_bit, rx_word_done, tx_load;

  // Receive path.
  logic [DATA_SIZE-1:0] rx_shift_reg;
  logic [CNT_W-1:0]     bit_cnt_reg;
  logic                 wr_pending_reg;
  logic                 overflow_reg;

  // Transmit path.
  logic [DATA_SIZE-1:0] tx_hold_reg;
  logic                 tx_full_reg;
  logic                 in_done_reg;
  logic [DATA_SIZE-1:0] tx_shift_reg;
  logic                 tx_zero_reg;
  logic                 underrun_reg;

  // Push handshake.
  push_state_t          state_reg, state_next;
  logic                 fifo_pop;
  logic [DATA_SIZE-1:0] fifo_head;
  logic                 fifo_full, fifo_empty;

  // Bring the asynchronous SPI pins into the clk domain. nCS settles to its
  // inactive (high) level so reset never looks like a selected bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ncs_meta_reg  <= 1'b1;
      ncs_sync_reg  <= 1'b1;
      ncs_prev_reg  <= 1'b1;
      sclk_meta_reg <= SCLK_IDLE;
      sclk_sync_reg <= SCLK_IDLE;
      sclk_prev_reg <= SCLK_IDLE;
      mosi_meta_reg <= 1'b0;
      mosi_sync_reg <= 1'b0;
    end else begin
      ncs_meta_reg  <= nCS;
      ncs_sync_reg  <= ncs_meta_reg;
      ncs_prev_reg  <= ncs_sync_reg;
      sclk_meta_reg <= SCLK;
      sclk_sync_reg <= sclk_meta_reg;
      sclk_prev_reg <= sclk_sync_reg;
      mosi_meta_reg <= MOSI;
      mosi_sync_reg <= mosi_meta_reg;
    end
  end

  assign selected     = !ncs_sync_reg;
  assign sclk_rise    = sclk_sync_reg && !sclk_prev_reg;
  assign sclk_fall    = !sclk_sync_reg && sclk_prev_reg;
  assign ncs_rise     = ncs_sync_reg && !ncs_prev_reg;
  assign ncs_fall     = !ncs_sync_reg && ncs_prev_reg;
  assign rx_bit       = sclk_rise && selected;
  assign rx_word_done = rx_bit && (bit_cnt_reg == LAST_BIT);

  // A new TX word is needed when the bus is selected, and on the first SCLK
  // fall after a completed word (counter back at 0). Loading on that fall
  // rather than on the last rise keeps the fresh MSB from being shifted away.
  assign tx_load = selected && (ncs_fall || (sclk_fall && (bit_cnt_reg == '0)));

  // Shift MOSI in on SCLK rises; a completed word schedules a FIFO write for
  // the following cycle. Deselecting mid-word abandons the partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift_reg   <= '0;
      bit_cnt_reg    <= '0;
      wr_pending_reg <= 1'b0;
    end else begin
      wr_pending_reg <= rx_word_done;
      if (ncs_rise) begin
        bit_cnt_reg <= '0;
      end else if (rx_bit) begin
        rx_shift_reg <= {rx_shift_reg[DATA_SIZE-2:0], mosi_sync_reg};
        bit_cnt_reg  <= rx_word_done ? '0 : bit_cnt_reg + 1'b1;
      end
    end
  end

  // Sticky flag for a completed word that found the FIFO full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_pending_reg && fifo_full) begin
      overflow_reg <= 1'b1;
    end
  end

  spi_rx_fifo #(
    .DATA_SIZE  (DATA_SIZE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_pending_reg),
    .wr_data (rx_shift_reg),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Push FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Push FSM next state: present the FIFO head, wait for the consumer, pop.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = REQUEST;
        end
      end
      REQUEST: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (out_done) begin
          fifo_pop   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign out_request = (state_reg == REQUEST);
  assign out_data    = (state_reg == IDLE) ? '0 : fifo_head;

  // One-deep TX holding register: accept a word only while empty and
  // acknowledge it one cycle later; a load towards the shifter empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_hold_reg <= '0;
      tx_full_reg <= 1'b0;
      in_done_reg <= 1'b0;
    end else begin
      in_done_reg <= 1'b0;
      if (tx_load) begin
        tx_full_reg <= 1'b0;
      end
      if (in_request && !tx_full_reg) begin
        tx_hold_reg <= in_data;
        tx_full_reg <= 1'b1;
        in_done_reg <= 1'b1;
      end
    end
  end

  // TX shifter: load the held word (or zeros when nothing is held) at a word
  // start, otherwise shift towards the MSB on each SCLK fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_reg <= '0;
      tx_zero_reg  <= 1'b0;
    end else begin
      if (ncs_rise) begin
        tx_zero_reg <= 1'b0;
      end else if (tx_load) begin
        tx_shift_reg <= tx_full_reg ? tx_hold_reg : '0;
        tx_zero_reg  <= !tx_full_reg;
      end else if (sclk_fall && selected) begin
        tx_shift_reg <= {tx_shift_reg[DATA_SIZE-2:0], 1'b0};
      end
    end
  end

  // Underrun is flagged only when the master actually clocks the first bit of
  // a zero-filled word; a trailing load after the last word of a transfer,
  // followed by deselect, is not an underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_reg <= 1'b0;
    end else if (tx_zero_reg && rx_bit && (bit_cnt_reg == '0)) begin
      underrun_reg <= 1'b1;
    end
  end

  assign MISO     = selected && tx_shift_reg[DATA_SIZE-1];
  assign in_done  = in_done_reg;
  assign overflow = overflow_reg;
  assign underrun = underrun_reg;

endmodule
